otg_hpi_pio: RTL and testbench
==============================

OTG_HPI_PIO -- requirements
Module: otg_hpi_pio

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the port width (legal range 1..32).
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, giving the input synchroniser depth (legal range 2..4).
REQ-003 The module SHALL have parameter RESET_VALUE, default 0, giving the reset value of the output data register (DATA_WIDTH bits).
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-009 writedata  input  32  Avalon-MM write data; bits above DATA_WIDTH-1 ignored.
REQ-010 readdata  output  32  Avalon-MM read data, registered; bits above DATA_WIDTH-1 zero.
REQ-011 in_port  input  DATA_WIDTH  asynchronous pin inputs.
REQ-012 out_port  output  DATA_WIDTH  output data register.
REQ-013 oe  output  DATA_WIDTH  per-bit output enable (1 = drive pin).
REQ-014 irq  output  1  level interrupt, active-high.

Function
REQ-015 Register map: 0 DATA (read = synchronised in_port where oe=0, out_port where oe=1; write = out_port), 1 DIR (R/W, drives oe), 2 IRQMASK (R/W), 3 EDGECAP (read; write-1-to-clear), 4 OUTSET, 5 OUTCLR, 6-7 reserved (read 0, writes ignored).
REQ-016 A write SHALL occur when chipselect=1 and write_n=0; the register updates on that clock edge.
REQ-017 readdata SHALL be loaded every cycle from the read mux for the current address, regardless of chipselect; read latency exactly 1 cycle.
REQ-018 in_port SHALL pass through SYNC_STAGES flops; DATA reads and edge detection SHALL use only the last synchroniser stage.
REQ-019 Edge detect: EDGECAP bit n SHALL set in the cycle after synchronised bit n goes 0->1 while DIR bit n = 0; output-mode bits never set EDGECAP.
REQ-020 EDGECAP write-1-to-clear: a written 1 clears the bit; if a new edge on that bit occurs in the same cycle, the bit SHALL remain set (edge wins).
REQ-021 irq SHALL equal OR over (EDGECAP & IRQMASK), combinational from those registers (no added latency).
REQ-022 Changing DIR bit from 1 to 0 SHALL NOT itself create an edge; the previous-value flop tracks the synchronised input continuously.
REQ-023 Latency: pin rise to EDGECAP set = SYNC_STAGES+1 cycles; to irq = same.

Reset
REQ-024 On reset_n low, asynchronously: out_port=RESET_VALUE, DIR=0, oe=0, IRQMASK=0, EDGECAP=0, synchroniser and previous-value flops=0, readdata=0, irq=0.
REQ-025 Reset asserted mid-operation SHALL discard pending edges; the first cycle after release SHALL NOT capture an edge from reset-state flops unless a real 0->1 occurs on the synchronised input.

Configuration
REQ-026 Macro OTG_HPI_PIO_BITSET_EN defined: write to OUTSET sets out_port bits where writedata=1; OUTCLR clears them; simultaneous set/clear impossible (single address per write); both read as 0.
REQ-027 OTG_HPI_PIO_BITSET_EN undefined: addresses 4-5 behave as reserved (writes ignored, read 0) and no set/clear logic is instantiated.

Verification
REQ-028 Reset, then read addresses 0-7 with in_port=0 -> readdata 0 everywhere except DATA = RESET_VALUE bits only where oe=1 (none) -> 0x0000; irq=0.
REQ-029 Write DIR=0x00FF, DATA=0xA5C3 -> oe=0x00FF, out_port=0xA5C3; with in_port=0x1200, read DATA -> 0x12C3 one cycle after address presented.
REQ-030 DIR=0, IRQMASK=0x0004, drive in_port bit 2 high -> EDGECAP=0x0004 and irq=1 exactly 3 cycles later (SYNC_STAGES=2); write EDGECAP=0x0004 -> irq=0 next cycle.
REQ-031 Write EDGECAP=0x0001 in the same cycle a synchronised edge on bit 0 arrives -> EDGECAP bit 0 stays 1.
REQ-032 With OTG_HPI_PIO_BITSET_EN: DATA=0x00F0, OUTSET=0x0003, OUTCLR=0x0010 -> out_port=0x00E3; without macro same sequence -> out_port=0x00F0.
REQ-033 DATA_WIDTH=8: write 0xFFFF_FFFF to DATA -> out_port=0xFF, readdata[31:8]=0 on all reads.

Source files
------------

// File: rtl/otg_hpi_pio.sv
// otg_hpi_pio: Avalon-MM parallel I/O port with per-bit direction, input synchroniser,
// rising-edge capture and maskable level interrupt.
// Optional feature: define OTG_HPI_PIO_BITSET_EN to enable the OUTSET (4) / OUTCLR (5)
// bit-set and bit-clear registers; otherwise addresses 4-5 are reserved.

module otg_hpi_pio #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    localparam logic [2:0] AddrData = 3'd0;
    localparam logic [2:0] AddrDir  = 3'd1;
    localparam logic [2:0] AddrMask = 3'd2;
    localparam logic [2:0] AddrCap  = 3'd3;
`ifdef OTG_HPI_PIO_BITSET_EN
    localparam logic [2:0] AddrSet  = 3'd4;
    localparam logic [2:0] AddrClr  = 3'd5;
`endif

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rise;
    logic [31:0]           rd_d;
    logic                  wr_en;
    logic                  unused_writedata;

    assign wr_en   = chipselect & ~write_n;
    assign wdata   = writedata[DATA_WIDTH-1:0];
    assign in_sync = sync_q[SYNC_STAGES-1];
    // Bits above DATA_WIDTH are deliberately ignored.
    assign unused_writedata = ^writedata;

    // Only input-mode bits can capture; prev_q follows the pin regardless of direction so a
    // direction change never manufactures an edge.
    assign rise = in_sync & ~prev_q & ~dir_q;

    // Input synchroniser chain and previous-value flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q <= in_sync;
        end
    end

    // Register write decode and edge capture next-state.
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en) begin
            case (address)
                AddrData: out_d  = wdata;
                AddrDir:  dir_d  = wdata;
                AddrMask: mask_d = wdata;
                AddrCap:  cap_d  = cap_q & ~wdata;
`ifdef OTG_HPI_PIO_BITSET_EN
                AddrSet:  out_d  = out_q | wdata;
                AddrClr:  out_d  = out_q & ~wdata;
`endif
                default:  ;
            endcase
        end
        // A new edge overrides a same-cycle clear.
        cap_d = cap_d | rise;
    end

    // Read mux; loaded into readdata every cycle regardless of chipselect.
    always_comb begin
        rd_d = '0;
        case (address)
            AddrData: rd_d[DATA_WIDTH-1:0] = (in_sync & ~dir_q) | (out_q & dir_q);
            AddrDir:  rd_d[DATA_WIDTH-1:0] = dir_q;
            AddrMask: rd_d[DATA_WIDTH-1:0] = mask_q;
            AddrCap:  rd_d[DATA_WIDTH-1:0] = cap_q;
            default:  ;
        endcase
    end

    // Control/status registers and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= RESET_VALUE;
            dir_q    <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            readdata <= '0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            readdata <= rd_d;
        end
    end

    assign out_port = out_q;
    assign oe       = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_otg_hpi_pio.sv
// Self-checking bench for otg_hpi_pio: a 16-bit instance driven from a vector table plus
// hand-written edge/reset sequences (reads checked through a scoreboard queue), and an 8-bit
// instance with a non-zero reset value for width truncation.

module tb_otg_hpi_pio;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // 16-bit instance
    logic [2:0]  a_addr;
    logic        a_cs, a_wn;
    logic [31:0] a_wdata, a_rdata;
    logic [15:0] a_pins, a_out, a_oe;
    logic        a_irq;

    // 8-bit instance
    logic [2:0]  b_addr;
    logic        b_cs, b_wn;
    logic [31:0] b_wdata, b_rdata;
    logic [7:0]  b_pins, b_out, b_oe;
    logic        b_irq;

    otg_hpi_pio #(
        .DATA_WIDTH  (16),
        .SYNC_STAGES (2)
    ) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (a_addr),
        .chipselect (a_cs),
        .write_n    (a_wn),
        .writedata  (a_wdata),
        .readdata   (a_rdata),
        .in_port    (a_pins),
        .out_port   (a_out),
        .oe         (a_oe),
        .irq        (a_irq)
    );

    otg_hpi_pio #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2),
        .RESET_VALUE (8'h5A)
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (b_addr),
        .chipselect (b_cs),
        .write_n    (b_wn),
        .writedata  (b_wdata),
        .readdata   (b_rdata),
        .in_port    (b_pins),
        .out_port   (b_out),
        .oe         (b_oe),
        .irq        (b_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected read data queued when the address is driven, compared when
    // readdata is produced one cycle later.
    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t  sb_q[$];
    logic rd_req = 1'b0;
    logic rd_seen;

    always @(posedge clk) rd_seen <= rd_req;

    always @(negedge clk) begin : mon
        sb_t e;
        if (rd_seen === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got no entry expected one");
            end else begin
                e = sb_q.pop_front();
                chk(e.name, a_rdata, e.exp);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic a_wr(input logic [2:0] addr, input logic [31:0] data);
        a_addr  = addr;
        a_cs    = 1'b1;
        a_wn    = 1'b0;
        a_wdata = data;
        rd_req  = 1'b0;
        @(negedge clk);
        a_cs = 1'b0;
        a_wn = 1'b1;
    endtask

    task automatic a_rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
        sb_t s;
        a_addr = addr;
        a_cs   = 1'b1;
        a_wn   = 1'b1;
        rd_req = 1'b1;
        s.exp  = exp;
        s.name = name;
        sb_q.push_back(s);
        @(negedge clk);
        rd_req = 1'b0;
        a_cs   = 1'b0;
    endtask

    task automatic b_wr(input logic [2:0] addr, input logic [31:0] data);
        b_addr  = addr;
        b_cs    = 1'b1;
        b_wn    = 1'b0;
        b_wdata = data;
        @(negedge clk);
        b_cs = 1'b0;
        b_wn = 1'b1;
    endtask

    // Reads with chipselect low: readdata still follows the address.
    task automatic b_rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
        b_addr = addr;
        b_cs   = 1'b0;
        b_wn   = 1'b1;
        @(negedge clk);
        chk(name, b_rdata, exp);
    endtask

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;   // write data, or expected read data
        logic [15:0] pins;
        string       name;
    } vec_t;

    function automatic vec_t mk(input bit wr, input logic [2:0] addr, input logic [31:0] data,
                                input logic [15:0] pins, input string name);
        vec_t v;
        v.wr   = wr;
        v.addr = addr;
        v.data = data;
        v.pins = pins;
        v.name = name;
        return v;
    endfunction

    localparam int NV = 22;
    vec_t tbl[NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(1, 3'd1, 32'h0000_00FF, 16'h1200, "wr_dir");
        tbl[1]  = mk(1, 3'd0, 32'hFFFF_A5C3, 16'h1200, "wr_data");
        tbl[2]  = mk(0, 3'd0, 32'h0000_12C3, 16'h1200, "rd_data_mixed");
        tbl[3]  = mk(0, 3'd1, 32'h0000_00FF, 16'h1200, "rd_dir");
        tbl[4]  = mk(0, 3'd2, 32'h0000_0000, 16'h1200, "rd_mask");
        tbl[5]  = mk(0, 3'd4, 32'h0000_0000, 16'h1200, "rd_addr4");
        tbl[6]  = mk(0, 3'd5, 32'h0000_0000, 16'h1200, "rd_addr5");
        tbl[7]  = mk(0, 3'd7, 32'h0000_0000, 16'h1200, "rd_addr7");
        tbl[8]  = mk(0, 3'd3, 32'h0000_1200, 16'h1200, "rd_cap_inputs");
        tbl[9]  = mk(1, 3'd3, 32'h0000_FFFF, 16'h1200, "w1c_all");
        tbl[10] = mk(0, 3'd3, 32'h0000_0000, 16'h1200, "rd_cap_cleared");
        tbl[11] = mk(1, 3'd1, 32'h0000_0000, 16'h1200, "wr_dir_in");
        tbl[12] = mk(0, 3'd0, 32'h0000_1200, 16'h1200, "rd_data_all_in");
        tbl[13] = mk(1, 3'd1, 32'h0000_FFFF, 16'h1200, "wr_dir_out");
        tbl[14] = mk(0, 3'd0, 32'h0000_A5C3, 16'h1200, "rd_data_all_out");
        tbl[15] = mk(1, 3'd6, 32'h0000_FFFF, 16'h1200, "wr_rsvd6");
        tbl[16] = mk(0, 3'd6, 32'h0000_0000, 16'h1200, "rd_rsvd6");
        tbl[17] = mk(0, 3'd0, 32'h0000_A5C3, 16'h1200, "rd_data_after_rsvd");
        tbl[18] = mk(1, 3'd2, 32'h0000_0005, 16'h1200, "wr_mask");
        tbl[19] = mk(0, 3'd2, 32'h0000_0005, 16'h1200, "rd_mask_back");
        tbl[20] = mk(1, 3'd7, 32'h0000_1234, 16'h1200, "wr_rsvd7");
        tbl[21] = mk(0, 3'd7, 32'h0000_0000, 16'h1200, "rd_rsvd7");

        reset_n = 1'b0;
        a_addr = '0; a_cs = 1'b0; a_wn = 1'b1; a_wdata = '0; a_pins = '0;
        b_addr = '0; b_cs = 1'b0; b_wn = 1'b1; b_wdata = '0; b_pins = '0;
        #12;
        chk("rst_readdata", a_rdata, 32'h0);
        chk("rst_out", {16'h0, a_out}, 32'h0);
        chk("rst_oe", {16'h0, a_oe}, 32'h0);
        chk("rst_irq", {31'h0, a_irq}, 32'h0);
        chk("rst_b_out", {24'h0, b_out}, 32'h5A);
        chk("rst_b_oe", {24'h0, b_oe}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // All addresses read zero out of reset with pins low.
        for (int i = 0; i < 8; i++) a_rd(3'(i), 32'h0, $sformatf("reset_rd%0d", i));
        chk("reset_irq", {31'h0, a_irq}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            a_pins = tbl[i].pins;
            if (tbl[i].wr) a_wr(tbl[i].addr, tbl[i].data);
            else           a_rd(tbl[i].addr, tbl[i].data, tbl[i].name);
        end
        chk("tbl_out", {16'h0, a_out}, 32'hA5C3);
        chk("tbl_oe", {16'h0, a_oe}, 32'hFFFF);
        chk("tbl_irq", {31'h0, a_irq}, 32'h0);

        // Pin rise to EDGECAP/irq takes exactly three cycles.
        a_wr(3'd1, 32'h0);
        a_wr(3'd2, 32'h4);
        a_pins = 16'h0000;
        idle(4);
        a_wr(3'd3, 32'hFFFF);
        chk("irq_idle", {31'h0, a_irq}, 32'h0);
        a_pins = 16'h0004;
        idle(2);
        chk("irq_at_2", {31'h0, a_irq}, 32'h0);
        idle(1);
        chk("irq_at_3", {31'h0, a_irq}, 32'h1);
        a_rd(3'd3, 32'h4, "cap_bit2");
        a_wr(3'd3, 32'h4);
        chk("irq_cleared", {31'h0, a_irq}, 32'h0);

        // Clear written in the same cycle a new edge arrives: edge wins.
        a_pins = 16'h0005;
        idle(4);
        a_pins = 16'h0004;
        idle(4);
        a_pins = 16'h0005;
        idle(2);
        a_wr(3'd3, 32'h1);
        a_rd(3'd3, 32'h1, "edge_wins");
        a_wr(3'd3, 32'h1);
        a_rd(3'd3, 32'h0, "w1c_no_edge");

        // Output-mode bits never capture, and switching to input creates no edge.
        a_wr(3'd1, 32'h8);
        a_pins = 16'h000D;
        idle(4);
        a_rd(3'd3, 32'h0, "out_mode_no_cap");
        a_rd(3'd0, 32'h5, "rd_data_bit3_out");
        a_wr(3'd1, 32'h0);
        idle(3);
        a_rd(3'd3, 32'h0, "dir_fall_no_edge");
        a_rd(3'd0, 32'hD, "rd_data_in");

        // Bit set / bit clear registers.
        a_wr(3'd0, 32'h00F0);
        a_wr(3'd4, 32'h0003);
        a_wr(3'd5, 32'h0010);
`ifdef OTG_HPI_PIO_BITSET_EN
        chk("bitset_out", {16'h0, a_out}, 32'h00E3);
`else
        chk("bitset_out", {16'h0, a_out}, 32'h00F0);
`endif
        a_rd(3'd4, 32'h0, "rd_outset");
        a_rd(3'd5, 32'h0, "rd_outclr");

        // Narrow instance: upper write bits dropped, upper read bits zero.
        b_wr(3'd0, 32'hFFFF_FFFF);
        chk("b_out_trunc", {24'h0, b_out}, 32'hFF);
        b_wr(3'd1, 32'hFFFF_FFFF);
        chk("b_oe_trunc", {24'h0, b_oe}, 32'hFF);
        b_rd(3'd0, 32'h0000_00FF, "b_rd_data");
        b_rd(3'd1, 32'h0000_00FF, "b_rd_dir");
        b_rd(3'd2, 32'h0, "b_rd_mask");

        // Reset mid-operation discards a pending edge and interrupt.
        a_wr(3'd2, 32'h20);
        a_pins = 16'h002D;
        idle(4);
        chk("pre_rst_irq", {31'h0, a_irq}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_irq", {31'h0, a_irq}, 32'h0);
        chk("mid_rst_out", {16'h0, a_out}, 32'h0);
        chk("mid_rst_oe", {16'h0, a_oe}, 32'h0);
        chk("mid_rst_readdata", a_rdata, 32'h0);
        chk("mid_rst_b_out", {24'h0, b_out}, 32'h5A);
        a_pins = 16'h0000;
        idle(2);
        reset_n = 1'b1;
        idle(5);
        a_rd(3'd3, 32'h0, "post_rst_cap");
        a_rd(3'd1, 32'h0, "post_rst_dir");
        chk("post_rst_irq", {31'h0, a_irq}, 32'h0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
